// File: rtl/cv32e40p_error_monitor.sv
// Error collector for cv32e40p: sticky per-source status, first-error record, saturating
// error-cycle counter and alarm irq behind a req/gnt register port. CV32E40P_ERRMON_FATAL_EN adds fatal_o.
module cv32e40p_error_monitor #(
  parameter int unsigned NUM_SRC = 47,
  parameter int unsigned CNT_W   = 16
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic [NUM_SRC-1:0] err_i,
  input  logic               cfg_req_i,
  input  logic               cfg_we_i,
  input  logic [2:0]         cfg_addr_i,
  input  logic [31:0]        cfg_wdata_i,
  output logic               cfg_gnt_o,
  output logic               cfg_rvalid_o,
  output logic [31:0]        cfg_rdata_o,
  output logic               irq_o
`ifdef CV32E40P_ERRMON_FATAL_EN
  ,
  output logic               fatal_o
`endif
);

  localparam logic [63:0] SRC_MASK = (NUM_SRC >= 64) ? {64{1'b1}} : ((64'd1 << NUM_SRC) - 64'd1);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1'b1);

  localparam logic [2:0] A_STATUS_LO = 3'd0;
  localparam logic [2:0] A_STATUS_HI = 3'd1;
  localparam logic [2:0] A_MASK_LO   = 3'd2;
  localparam logic [2:0] A_MASK_HI   = 3'd3;
  localparam logic [2:0] A_FIRST     = 3'd4;
  localparam logic [2:0] A_COUNT     = 3'd5;
  localparam logic [2:0] A_THRESH    = 3'd6;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ALARM = 2'd1;
`ifdef CV32E40P_ERRMON_FATAL_EN
  localparam logic [1:0] FATAL = 2'd2;
`endif

  function automatic logic [5:0] lowest_idx(input logic [63:0] v);
    lowest_idx = 6'd0;
    for (int i = 63; i >= 0; i--) begin
      if (v[i]) begin
        lowest_idx = i[5:0];
      end
    end
  endfunction

  function automatic logic [31:0] zext_cnt(input logic [CNT_W-1:0] v);
    zext_cnt = 32'd0;
    zext_cnt[CNT_W-1:0] = v;
  endfunction

  logic [63:0]      status_q, status_d;
  logic [63:0]      mask_q, mask_d;
  logic             first_valid_q, first_valid_d;
  logic [5:0]       first_idx_q, first_idx_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [CNT_W-1:0] thresh_q, thresh_d;
  logic [1:0]       state_q, state_d;
  logic             irq_q, irq_d;
  logic             fatal_q, fatal_d;
  logic             rvalid_q, rvalid_d;
  logic [31:0]      rdata_q, rdata_d;

  logic [63:0]      err_ext;
  logic [63:0]      w1c;
  logic [63:0]      ue_vec;
  logic             ue;
  logic             wr_en;
  logic             rd_en;
  logic             cfg_lock;
  logic             first_base;
  logic [CNT_W-1:0] count_base;
  logic             pend_next;
  logic [31:0]      rd_val;

  assign wr_en     = cfg_req_i & cfg_we_i;
  assign rd_en     = cfg_req_i & ~cfg_we_i;
  assign cfg_gnt_o = 1'b1;

  // Zero-extend the source vector to the 64-bit register map
  always_comb begin
    err_ext = 64'd0;
    err_ext[NUM_SRC-1:0] = err_i;
  end

`ifdef CV32E40P_ERRMON_FATAL_EN
  assign cfg_lock = (state_q == FATAL);
`else
  assign cfg_lock = 1'b0;
`endif

  // Status, mask, FIRST, COUNT and THRESH next-state; the old mask qualifies this cycle's errors
  always_comb begin
    w1c = 64'd0;
    if (wr_en && (cfg_addr_i == A_STATUS_LO)) begin
      w1c[31:0] = cfg_wdata_i;
    end else if (wr_en && (cfg_addr_i == A_STATUS_HI)) begin
      w1c[63:32] = cfg_wdata_i;
    end else begin
      w1c = 64'd0;
    end
    status_d = ((status_q & ~w1c) | err_ext) & SRC_MASK;

    mask_d = mask_q;
    if (wr_en && !cfg_lock && (cfg_addr_i == A_MASK_LO)) begin
      mask_d[31:0] = cfg_wdata_i;
    end else if (wr_en && !cfg_lock && (cfg_addr_i == A_MASK_HI)) begin
      mask_d[63:32] = cfg_wdata_i;
    end else begin
      mask_d = mask_q;
    end
    mask_d = mask_d & SRC_MASK;

    ue_vec = err_ext & ~mask_q;
    ue     = |ue_vec;

    // A FIRST write clears before capture, so a simultaneous error is still recorded
    first_base = (wr_en && (cfg_addr_i == A_FIRST)) ? 1'b0 : first_valid_q;
    if (ue && !first_base) begin
      first_valid_d = 1'b1;
      first_idx_d   = lowest_idx(ue_vec);
    end else if (!first_base) begin
      first_valid_d = 1'b0;
      first_idx_d   = 6'd0;
    end else begin
      first_valid_d = first_valid_q;
      first_idx_d   = first_idx_q;
    end

    count_base = (wr_en && !cfg_lock && (cfg_addr_i == A_COUNT)) ? {CNT_W{1'b0}} : count_q;
    if (ue && (count_base != CNT_MAX)) begin
      count_d = count_base + CNT_ONE;
    end else begin
      count_d = count_base;
    end

    if (wr_en && !cfg_lock && (cfg_addr_i == A_THRESH)) begin
      thresh_d = cfg_wdata_i[CNT_W-1:0];
    end else begin
      thresh_d = thresh_q;
    end
  end

  // Alarm state machine driven by the post-edge pending set
  always_comb begin
    pend_next = |(status_d & ~mask_d);
    case (state_q)
      IDLE:    state_d = pend_next ? ALARM : IDLE;
      ALARM:   state_d = pend_next ? ALARM : IDLE;
`ifdef CV32E40P_ERRMON_FATAL_EN
      FATAL:   state_d = FATAL;
`endif
      default: state_d = IDLE;
    endcase
`ifdef CV32E40P_ERRMON_FATAL_EN
    if ((thresh_q != {CNT_W{1'b0}}) && (count_d >= thresh_q)) begin
      state_d = FATAL;
    end else begin
      state_d = state_d;
    end
    fatal_d = (state_d == FATAL);
    irq_d   = (state_d == ALARM) || (state_d == FATAL);
`else
    fatal_d = 1'b0;
    irq_d   = (state_d == ALARM);
`endif
  end

  // Register read mux; reads see pre-edge state, writes answer with zero data
  always_comb begin
    case (cfg_addr_i)
      A_STATUS_LO: rd_val = status_q[31:0];
      A_STATUS_HI: rd_val = status_q[63:32];
      A_MASK_LO:   rd_val = mask_q[31:0];
      A_MASK_HI:   rd_val = mask_q[63:32];
      A_FIRST:     rd_val = {first_valid_q, 25'd0, first_idx_q};
      A_COUNT:     rd_val = zext_cnt(count_q);
      A_THRESH:    rd_val = zext_cnt(thresh_q);
      default:     rd_val = 32'd0;
    endcase
    if (rd_en) begin
      rdata_d = rd_val;
    end else begin
      rdata_d = 32'd0;
    end
    rvalid_d = cfg_req_i;
  end

  // State registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      status_q      <= 64'd0;
      mask_q        <= 64'd0;
      first_valid_q <= 1'b0;
      first_idx_q   <= 6'd0;
      count_q       <= {CNT_W{1'b0}};
      thresh_q      <= {CNT_W{1'b0}};
      state_q       <= IDLE;
      irq_q         <= 1'b0;
      fatal_q       <= 1'b0;
      rvalid_q      <= 1'b0;
      rdata_q       <= 32'd0;
    end else begin
      status_q      <= status_d;
      mask_q        <= mask_d;
      first_valid_q <= first_valid_d;
      first_idx_q   <= first_idx_d;
      count_q       <= count_d;
      thresh_q      <= thresh_d;
      state_q       <= state_d;
      irq_q         <= irq_d;
      fatal_q       <= fatal_d;
      rvalid_q      <= rvalid_d;
      rdata_q       <= rdata_d;
    end
  end

  assign irq_o        = irq_q;
  assign cfg_rvalid_o = rvalid_q;
  assign cfg_rdata_o  = rdata_q;
`ifdef CV32E40P_ERRMON_FATAL_EN
  assign fatal_o = fatal_q;
`else
  logic unused_fatal;
  assign unused_fatal = fatal_q;
`endif

endmodule

// File: tb/tb_cv32e40p_error_monitor.sv
// Directed bench for cv32e40p_error_monitor (NUM_SRC=47, CNT_W=4); inputs driven on negedge, outputs sampled on negedge.
module tb_cv32e40p_error_monitor;

  localparam int NSRC = 47;

  logic            clk_i = 1'b0;
  logic            rst_ni;
  logic [NSRC-1:0] err_i;
  logic            cfg_req_i;
  logic            cfg_we_i;
  logic [2:0]      cfg_addr_i;
  logic [31:0]     cfg_wdata_i;
  logic            cfg_gnt_o;
  logic            cfg_rvalid_o;
  logic [31:0]     cfg_rdata_o;
  logic            irq_o;
`ifdef CV32E40P_ERRMON_FATAL_EN
  logic            fatal_o;
`endif

  int n_checks = 0;
  int n_pass   = 0;
  logic [31:0] rd;

  always #5 clk_i = ~clk_i;

  cv32e40p_error_monitor #(.NUM_SRC(NSRC), .CNT_W(4)) dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .err_i        (err_i),
    .cfg_req_i    (cfg_req_i),
    .cfg_we_i     (cfg_we_i),
    .cfg_addr_i   (cfg_addr_i),
    .cfg_wdata_i  (cfg_wdata_i),
    .cfg_gnt_o    (cfg_gnt_o),
    .cfg_rvalid_o (cfg_rvalid_o),
    .cfg_rdata_o  (cfg_rdata_o),
    .irq_o        (irq_o)
`ifdef CV32E40P_ERRMON_FATAL_EN
    ,
    .fatal_o      (fatal_o)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic cfg_write(input logic [2:0] addr, input logic [31:0] data);
    @(negedge clk_i);
    cfg_req_i = 1'b1; cfg_we_i = 1'b1; cfg_addr_i = addr; cfg_wdata_i = data;
    @(negedge clk_i);
    cfg_req_i = 1'b0; cfg_we_i = 1'b0;
    chk("wr_rvalid", {31'd0, cfg_rvalid_o}, 32'd1);
    chk("wr_rdata", cfg_rdata_o, 32'd0);
  endtask

  task automatic cfg_read(input logic [2:0] addr, output logic [31:0] data);
    @(negedge clk_i);
    cfg_req_i = 1'b1; cfg_we_i = 1'b0; cfg_addr_i = addr;
    @(negedge clk_i);
    cfg_req_i = 1'b0;
    chk("rd_rvalid", {31'd0, cfg_rvalid_o}, 32'd1);
    data = cfg_rdata_o;
  endtask

  task automatic pulse_err(input logic [63:0] v);
    @(negedge clk_i);
    err_i = v[NSRC-1:0];
    @(negedge clk_i);
    err_i = '0;
  endtask

  // Error on source src in the same cycle as a register write
  task automatic err_and_write(input int src, input logic [2:0] addr, input logic [31:0] data);
    @(negedge clk_i);
    err_i = '0; err_i[src] = 1'b1;
    cfg_req_i = 1'b1; cfg_we_i = 1'b1; cfg_addr_i = addr; cfg_wdata_i = data;
    @(negedge clk_i);
    err_i = '0; cfg_req_i = 1'b0; cfg_we_i = 1'b0;
    chk("ew_rvalid", {31'd0, cfg_rvalid_o}, 32'd1);
  endtask

  initial begin
    rst_ni = 1'b0; err_i = '0; cfg_req_i = 1'b0; cfg_we_i = 1'b0;
    cfg_addr_i = 3'd0; cfg_wdata_i = 32'd0;
    repeat (3) @(negedge clk_i);
    chk("rst_irq", {31'd0, irq_o}, 32'd0);
    chk("rst_rvalid", {31'd0, cfg_rvalid_o}, 32'd0);
    chk("rst_rdata", cfg_rdata_o, 32'd0);
    chk("rst_gnt", {31'd0, cfg_gnt_o}, 32'd1);
    rst_ni = 1'b1;

    for (int a = 0; a < 8; a++) begin
      cfg_read(a[2:0], rd);
      chk($sformatf("rst_reg%0d", a), rd, 32'd0);
    end

    // Two sources in one cycle
    pulse_err(64'h0000_0100_0000_0008);
    chk("dual_irq", {31'd0, irq_o}, 32'd1);
    cfg_read(3'd0, rd); chk("dual_stat_lo", rd, 32'h0000_0008);
    cfg_read(3'd1, rd); chk("dual_stat_hi", rd, 32'h0000_0100);
    cfg_read(3'd4, rd); chk("dual_first", rd, 32'h8000_0003);
    cfg_read(3'd5, rd); chk("dual_count", rd, 32'd1);
    cfg_write(3'd0, 32'h0000_0008);
    chk("partclr_irq", {31'd0, irq_o}, 32'd1);
    cfg_write(3'd1, 32'h0000_0100);
    chk("fullclr_irq", {31'd0, irq_o}, 32'd0);
    cfg_write(3'd4, 32'd0);
    cfg_write(3'd5, 32'd0);
    cfg_read(3'd4, rd); chk("first_cleared", rd, 32'd0);
    cfg_read(3'd5, rd); chk("count_cleared", rd, 32'd0);

    // Masked source
    cfg_write(3'd2, 32'h0000_0008);
    cfg_read(3'd2, rd); chk("mask_lo_rb", rd, 32'h0000_0008);
    cfg_write(3'd3, 32'hFFFF_FFFF);
    cfg_read(3'd3, rd); chk("mask_hi_rb", rd, 32'h0000_7FFF);
    cfg_write(3'd3, 32'd0);
    pulse_err(64'h8);
    chk("masked_irq", {31'd0, irq_o}, 32'd0);
    cfg_read(3'd0, rd); chk("masked_stat", rd, 32'h0000_0008);
    cfg_read(3'd5, rd); chk("masked_count", rd, 32'd0);
    cfg_read(3'd4, rd); chk("masked_first", rd, 32'd0);
    cfg_write(3'd0, 32'h0000_0008);
    cfg_write(3'd2, 32'd0);
    chk("unmask_irq", {31'd0, irq_o}, 32'd0);

    // Set wins over W1C
    @(negedge clk_i);
    err_i = '0; err_i[0] = 1'b1;
    cfg_write(3'd0, 32'h1);
    chk("hold_irq", {31'd0, irq_o}, 32'd1);
    cfg_read(3'd0, rd); chk("hold_stat", rd, 32'h1);
    err_i = '0;
    @(negedge clk_i);
    chk("pre_clr_irq", {31'd0, irq_o}, 32'd1);
    cfg_write(3'd0, 32'h1);
    chk("post_clr_irq", {31'd0, irq_o}, 32'd0);
    cfg_write(3'd4, 32'd0);
    cfg_write(3'd5, 32'd0);

    // Saturation, then coincident writes
    for (int k = 0; k < 20; k++) pulse_err(64'h20);
    cfg_read(3'd5, rd); chk("count_sat", rd, 32'h0000_000F);
    cfg_read(3'd4, rd); chk("first_src5", rd, 32'h8000_0005);
    err_and_write(5, 3'd5, 32'h9);
    cfg_read(3'd5, rd); chk("count_wr_ue", rd, 32'd1);
    err_and_write(7, 3'd4, 32'd0);
    cfg_read(3'd4, rd); chk("first_wr_ue", rd, 32'h8000_0007);
    err_and_write(2, 3'd2, 32'h4);
    cfg_read(3'd5, rd); chk("old_mask_count", rd, 32'd3);
    cfg_read(3'd2, rd); chk("new_mask_rb", rd, 32'h4);
    cfg_read(3'd0, rd); chk("stat_a4", rd, 32'h0000_00A4);
    chk("a4_irq", {31'd0, irq_o}, 32'd1);
    cfg_write(3'd0, 32'h0000_00A0);
    chk("only_masked_irq", {31'd0, irq_o}, 32'd0);
    cfg_write(3'd2, 32'd0);
    chk("unmask_rise_irq", {31'd0, irq_o}, 32'd1);
    cfg_write(3'd0, 32'h4);
    chk("clr4_irq", {31'd0, irq_o}, 32'd0);
    cfg_write(3'd4, 32'd0);
    cfg_write(3'd5, 32'd0);

    // Threshold
    cfg_write(3'd6, 32'hFFFF_FFF3);
    cfg_read(3'd6, rd); chk("thresh_rb", rd, 32'd3);
`ifdef CV32E40P_ERRMON_FATAL_EN
    pulse_err(64'h2);
    pulse_err(64'h2);
    chk("fatal_pre", {31'd0, fatal_o}, 32'd0);
    pulse_err(64'h2);
    chk("fatal_rise", {31'd0, fatal_o}, 32'd1);
    chk("fatal_irq", {31'd0, irq_o}, 32'd1);
    cfg_write(3'd5, 32'd0);
    cfg_read(3'd5, rd); chk("fatal_count_lock", rd, 32'd3);
    cfg_write(3'd0, 32'h2);
    cfg_read(3'd0, rd); chk("fatal_w1c", rd, 32'd0);
    chk("fatal_hold", {31'd0, fatal_o}, 32'd1);
    chk("fatal_irq_hold", {31'd0, irq_o}, 32'd1);
`else
    pulse_err(64'h2);
    pulse_err(64'h2);
    pulse_err(64'h2);
    cfg_read(3'd5, rd); chk("nofatal_count", rd, 32'd3);
    chk("nofatal_irq", {31'd0, irq_o}, 32'd1);
`endif

    // Reset with a read response in flight
    @(negedge clk_i);
    cfg_req_i = 1'b1; cfg_we_i = 1'b0; cfg_addr_i = 3'd5;
    @(posedge clk_i);
    #1;
    chk("inflight_rvalid", {31'd0, cfg_rvalid_o}, 32'd1);
    rst_ni = 1'b0;
    #1;
    chk("midrst_rvalid", {31'd0, cfg_rvalid_o}, 32'd0);
    chk("midrst_rdata", cfg_rdata_o, 32'd0);
    chk("midrst_irq", {31'd0, irq_o}, 32'd0);
`ifdef CV32E40P_ERRMON_FATAL_EN
    chk("midrst_fatal", {31'd0, fatal_o}, 32'd0);
`endif
    cfg_req_i = 1'b0;
    @(negedge clk_i);
    rst_ni = 1'b1;
    cfg_read(3'd5, rd); chk("post_rst_count", rd, 32'd0);
    cfg_read(3'd6, rd); chk("post_rst_thresh", rd, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/cv32e40p_error_monitor.md
# cv32e40p_error_monitor

Error collector placed directly downstream of the core top level. It samples every `error_detected_*`, `error_parity_*`, `error_load_store_o` and `error_prefech_buffer_parity_o` flag, concatenated into one vector. It turns these single-cycle flags into sticky status bits, a first-error record, a saturating error-cycle counter and an alarm interrupt. Software or the debug module reads and clears this state through a small req/gnt register port.

## Interface
- `NUM_SRC`, 47: number of error sources; legal range 1..64.
- `CNT_W`, 16: error-cycle counter width; legal range 1..32.
- `clk_i` in 1: core clock.
- `rst_ni` in 1: reset, asynchronous, active-low.
- `err_i` in NUM_SRC: error flags, sampled every cycle; bit order is fixed by the integration.
- `cfg_req_i` in 1: register access request.
- `cfg_we_i` in 1: 1 = write, 0 = read.
- `cfg_addr_i` in 3: register index.
- `cfg_wdata_i` in 32: write data.
- `cfg_gnt_o` out 1: grant; tied high (every request accepted in the request cycle).
- `cfg_rvalid_o` out 1: response valid, one cycle after request.
- `cfg_rdata_o` out 32: read data; 0 for writes and unmapped addresses.
- `irq_o` out 1: alarm; high while any unmasked status bit is set.
- `fatal_o` out 1: threshold reached; exists only with the macro (see Configuration).

## Operation
- Registers; bits beyond NUM_SRC read 0 and ignore writes.
  - 0 STATUS_LO, sources 31:0, write-1-to-clear.
  - 1 STATUS_HI, sources 63:32, write-1-to-clear.
  - 2 MASK_LO, read/write.
  - 3 MASK_HI, read/write.
  - 4 FIRST: bit31 valid, bits 5:0 source index; any write clears it.
  - 5 COUNT: zero-extended; any write sets it to 0.
  - 6 THRESH: CNT_W bits; 0 = disabled.
  - 7: unmapped.
- Status: `status[i]` is set for every `err_i[i]` high, masked or not. Mask affects irq, FIRST and COUNT only.
- Unmasked error cycle (UE): `|(err_i & ~mask)`.
- FIRST: on UE with FIRST.valid = 0, capture the lowest set unmasked index and set valid. Further errors are ignored until FIRST is cleared.
- COUNT: +1 per UE cycle (not per source); saturates at 2^CNT_W-1 with no wrap.
- FSM, registered, 2 states (3 with macro):
  - IDLE -> ALARM when the next `status & ~mask` is nonzero.
  - ALARM -> IDLE when it becomes zero, via clear or mask write.
  - `irq_o = (state == ALARM)`.
- Simultaneous events:
  - Error set and W1C of the same bit in one cycle: set wins, bit stays 1.
  - UE and FIRST write in one cycle: clear, then capture (new error recorded, valid = 1).
  - UE and COUNT write in one cycle: COUNT = 1.
  - Mask write and error in one cycle: the old mask applies to that cycle's error.
- Reset mid-operation clears all state immediately (asynchronous); a pending read response is dropped.

## Timing
- Reset values:
  - Status, mask, FIRST, COUNT and THRESH = 0.
  - State = IDLE.
  - irq_o, fatal_o, cfg_rvalid_o, cfg_rdata_o = 0.
  - cfg_gnt_o = 1.
- `err_i` high in cycle N -> status/FIRST/COUNT update at edge N+1; irq_o high in cycle N+1.
- Read in cycle N -> cfg_rvalid_o and cfg_rdata_o valid in cycle N+1 only. Data reflects state after edge N, i.e. excluding writes issued in cycle N.
- Write in cycle N -> effect at edge N+1. cfg_rvalid_o pulses in N+1 with rdata 0.
- Back-to-back requests every cycle are supported; each produces one response.

## Configuration
- `CV32E40P_ERRMON_FATAL_EN` defined:
  - Adds `fatal_o` and a FATAL state, entered from any state when THRESH != 0 and the next COUNT >= THRESH.
  - FATAL exits only on reset; fatal_o = irq_o = 1 in FATAL.
  - While in FATAL, writes to COUNT, THRESH and MASK are ignored; status W1C still works.
- Undefined: no fatal_o port and no FATAL state. THRESH reads back but has no effect.

## Test plan
- Reset, then read all 8 addresses -> every read returns 0; irq_o = 0.
- NUM_SRC = 47, err_i[3] and err_i[40] pulsed in the same cycle:
  - Irq rises one cycle later.
  - STATUS_LO = 0x8, STATUS_HI = 0x100.
  - FIRST = 0x80000003, COUNT = 1.
- MASK_LO = 0x8, then pulse err_i[3] -> STATUS_LO = 0x8; irq_o = 0, COUNT = 0, FIRST.valid = 0.
- Hold err_i[0] high continuously while writing STATUS_LO = 0x1 -> bit stays 1 and irq_o stays 1. Drop err_i[0], write again -> irq_o falls one cycle after the write.
- CNT_W = 4, pulse an error in 20 distinct cycles -> COUNT = 15 with no wrap. Write COUNT in a UE cycle -> COUNT = 1.
- With CV32E40P_ERRMON_FATAL_EN and THRESH = 3, pulse 3 errors -> fatal_o rises the cycle after the 3rd error. Writing COUNT = 0 is ignored; fatal_o clears only on rst_ni low.
